ex_epu_seq: RTL

//  Exception/return sequencer: the initiator side of the PSR/EPC/ELSA/EVECT MSR file.
//  - Accepts a synchronous exception, an interrupt request or an ERET from EX.
//  - Drives the MSR file's save/restore strobes and E* write ports in the fixed order

---
 rtl/ex_epu_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ex_epu_seq.sv
// ex_epu_seq: exception/return sequencer driving the PSR/EPC/ELSA/EVECT MSR file.
//   Accepts one of {sync exception, enabled IRQ, ERET} in IDLE (fixed priority),
//   then runs SAVE -> REDIR or RESTORE -> REDIR, ending with a one-shot redirect.
// Ports:
//   clk, rst                      clock, async active-high reset
//   exc_* / irq_* / eret_valid    requests from EX; req_ready = accepting (IDLE)
//   msr_psr_ire/evect/epc         bypassed MSR values read at accept / RESTORE
//   msr_psr_save/restore, msr_epc_*, msr_elsa_*   MSR file write side
//   flush, redirect_*             frontend kill + PC redirect handshake
//   busy                          sequencer not IDLE
module ex_epu_seq #(
  parameter int          CONFIG_DW  = 64,
  parameter int          VECT_SHIFT = 6,
  parameter logic [3:0]  IRQ_CAUSE  = 4'd8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exc_valid,
  input  logic [3:0]           exc_cause,
  input  logic [CONFIG_DW-1:0] exc_pc,
  input  logic [CONFIG_DW-1:0] exc_lsa,
  input  logic                 exc_lsa_vld,
  input  logic                 irq_req,
  input  logic [CONFIG_DW-1:0] irq_pc,
  input  logic                 eret_valid,
  output logic                 req_ready,
  input  logic                 msr_psr_ire,
  input  logic [CONFIG_DW-1:0] msr_evect,
  input  logic [CONFIG_DW-1:0] msr_epc,
  output logic                 msr_psr_save,
  output logic                 msr_psr_restore,
  output logic [CONFIG_DW-1:0] msr_epc_nxt,
  output logic                 msr_epc_we,
  output logic [CONFIG_DW-1:0] msr_elsa_nxt,
  output logic                 msr_elsa_we,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [CONFIG_DW-1:0] redirect_pc,
  input  logic                 redirect_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_SAVE, S_RESTORE, S_REDIR} state_e;

  state_e               state_q, state_d;
  logic [CONFIG_DW-1:0] pc_q, pc_d;
  logic [CONFIG_DW-1:0] lsa_q, lsa_d;
  logic                 lsa_vld_q, lsa_vld_d;
  logic [CONFIG_DW-1:0] tgt_q, tgt_d;

  logic                 irq_take;
  logic [3:0]           cause_sel;
  logic [CONFIG_DW-1:0] vec_tgt;

  // Vector target wraps modulo 2^CONFIG_DW by construction of the adder width.
  assign irq_take  = irq_req & msr_psr_ire;
  assign cause_sel = exc_valid ? exc_cause : IRQ_CAUSE;
  assign vec_tgt   = msr_evect + (CONFIG_DW'(cause_sel) << VECT_SHIFT);

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    lsa_d           = lsa_q;
    lsa_vld_d       = lsa_vld_q;
    tgt_d           = tgt_q;
    req_ready       = 1'b0;
    msr_psr_save    = 1'b0;
    msr_psr_restore = 1'b0;
    msr_epc_nxt     = '0;
    msr_epc_we      = 1'b0;
    msr_elsa_nxt    = '0;
    msr_elsa_we     = 1'b0;
    flush           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    busy            = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (exc_valid) begin
          pc_d      = exc_pc;
          lsa_d     = exc_lsa;
          lsa_vld_d = exc_lsa_vld;
          tgt_d     = vec_tgt;
          state_d   = S_SAVE;
        end else if (irq_take) begin
          pc_d      = irq_pc;
          lsa_d     = '0;
          lsa_vld_d = 1'b0;
          tgt_d     = vec_tgt;
          state_d   = S_SAVE;
        end else if (eret_valid) begin
          state_d   = S_RESTORE;
        end
      end
      S_SAVE: begin
        msr_psr_save = 1'b1;
        msr_epc_we   = 1'b1;
        msr_epc_nxt  = pc_q;
        msr_elsa_we  = lsa_vld_q;
        msr_elsa_nxt = lsa_q;
        flush        = 1'b1;
        state_d      = S_REDIR;
      end
      S_RESTORE: begin
        // EPC is sampled here, not at accept, so a same-cycle EPC write is seen.
        msr_psr_restore = 1'b1;
        flush           = 1'b1;
        tgt_d           = msr_epc;
        state_d         = S_REDIR;
      end
      S_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = tgt_q;
        if (redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      lsa_q     <= '0;
      lsa_vld_q <= 1'b0;
      tgt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      lsa_q     <= lsa_d;
      lsa_vld_q <= lsa_vld_d;
      tgt_q     <= tgt_d;
    end
  end

  a_save_restore_excl: assert property (@(posedge clk) disable iff (rst)
    !(msr_psr_save && msr_psr_restore));

endmodule
